ramp_sequencer: RTL

RAMP_SEQUENCER -- requirements
Module: ramp_sequencer

---
 rtl/ramp_sequencer_if.sv | 44 ++++
 rtl/ramp_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ramp_sequencer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ramp_sequencer_if
// Purpose  : Bundles the control, configuration and status signals of the
//            ramp sequencer. The slave modport is the sequencer's view and
//            the master modport is the view of whatever drives it.
// Signals  : start, abort           - run request / run termination
//            target, dwell, cycles  - run configuration, latched at start
//            count_in               - value of the external up/down counter
//            enable, updn           - counter enable and direction (1 = up)
//            busy, done, aborted    - run status and one-cycle pulses
//            state, cyc_done        - state encoding and completed cycles
// Revision : 1.0 - initial release
// ============================================================================
interface ramp_sequencer_if #(
    parameter int WIDTH  = 4,
    parameter int NCYC_W = 4
);
    logic              start;
    logic              abort;
    logic [WIDTH-1:0]  target;
    logic [NCYC_W-1:0] dwell;
    logic [NCYC_W-1:0] cycles;
    logic [WIDTH-1:0]  count_in;
    logic              enable;
    logic              updn;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [2:0]        state;
    logic [NCYC_W-1:0] cyc_done;

    modport slave (
        input  start, abort, target, dwell, cycles, count_in,
        output enable, updn, busy, done, aborted, state, cyc_done
    );

    modport master (
        output start, abort, target, dwell, cycles, count_in,
        input  enable, updn, busy, done, aborted, state, cyc_done
    );
endinterface
`default_nettype wire

// File: rtl/ramp_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ramp_sequencer
// Purpose  : Drives an external saturating up/down counter through repeated
//            ramps 0 -> target -> 0, with a programmable dwell at the peak
//            and at zero, a programmable number of cycles (0 = run until
//            aborted), and an abort path that brings the counter back to 0.
// Ports    : clk  - single clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - ramp_sequencer_if.slave (control, config, status)
// Revision : 1.0 - initial release
// ============================================================================
module ramp_sequencer #(
    parameter int WIDTH  = 4,
    parameter int NCYC_W = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    ramp_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEEK_HI = 3'd1,
        S_HOLD_HI = 3'd2,
        S_SEEK_LO = 3'd3,
        S_HOLD_LO = 3'd4,
        S_RETURN  = 3'd5
    } state_t;

    localparam logic [NCYC_W-1:0] c_CYC_MAX = '1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_tgt;
    logic [NCYC_W-1:0]  r_dwell;
    logic [NCYC_W-1:0]  r_cyc;
    logic [NCYC_W-1:0]  r_cyc_done;
    logic [NCYC_W-1:0]  r_dwell_cnt;
    logic               r_done;
    logic               r_aborted;

    logic               w_enable;
    logic               w_updn;
    logic               w_accept;
    logic               w_hold_load;
    logic               w_hold_dec;
    logic               w_cyc_step;
    logic               w_done_set;
    logic               w_aborted_set;
    logic               w_hold_last;
    logic               w_cnt_zero;
    logic [NCYC_W-1:0]  w_cyc_done_inc;

    assign w_hold_last    = (r_dwell_cnt == '0);
    assign w_cnt_zero     = (bus.count_in == '0);
    // Completed-cycle count saturates so a continuous run never wraps it.
    assign w_cyc_done_inc = (r_cyc_done == c_CYC_MAX) ? r_cyc_done
                                                      : r_cyc_done + 1'b1;

    always_comb begin
        w_state_nxt   = r_state;
        w_enable      = 1'b0;
        w_updn        = 1'b0;
        w_accept      = 1'b0;
        w_hold_load   = 1'b0;
        w_hold_dec    = 1'b0;
        w_cyc_step    = 1'b0;
        w_done_set    = 1'b0;
        w_aborted_set = 1'b0;

        case (r_state)
            S_IDLE: begin
                // START together with ABORT is treated as no request.
                if (bus.start && !bus.abort) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SEEK_HI;
                end
            end
            S_SEEK_HI: begin
                // Direction follows the comparison, so a counter already
                // above the target is walked down to it.
                w_enable = (bus.count_in != r_tgt);
                w_updn   = (bus.count_in < r_tgt);
                if (bus.abort) begin
                    w_state_nxt = S_RETURN;
                end else if (bus.count_in == r_tgt) begin
                    w_hold_load = 1'b1;
                    w_state_nxt = S_HOLD_HI;
                end
            end
            S_HOLD_HI: begin
                w_hold_dec = !w_hold_last;
                if (bus.abort) begin
                    w_state_nxt = S_RETURN;
                end else if (w_hold_last) begin
                    w_state_nxt = S_SEEK_LO;
                end
            end
            S_SEEK_LO: begin
                w_enable = !w_cnt_zero;
                if (bus.abort) begin
                    w_state_nxt = S_RETURN;
                end else if (w_cnt_zero) begin
                    w_hold_load = 1'b1;
                    w_state_nxt = S_HOLD_LO;
                end
            end
            S_HOLD_LO: begin
                w_hold_dec = !w_hold_last;
                if (w_hold_last) begin
                    // The cycle counts even when an abort arrives on the
                    // same edge; the abort only suppresses DONE.
                    w_cyc_step = 1'b1;
                    if (bus.abort) begin
                        w_state_nxt = S_RETURN;
                    end else if ((r_cyc != '0) && (w_cyc_done_inc == r_cyc)) begin
                        w_done_set  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_SEEK_HI;
                    end
                end else if (bus.abort) begin
                    w_state_nxt = S_RETURN;
                end
            end
            S_RETURN: begin
                w_enable = !w_cnt_zero;
                if (w_cnt_zero) begin
                    w_aborted_set = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tgt       <= '0;
            r_dwell     <= '0;
            r_cyc       <= '0;
            r_cyc_done  <= '0;
            r_dwell_cnt <= '0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            // DONE and ABORTED are registered: they pulse in the first
            // IDLE cycle after the run ends.
            r_done    <= w_done_set;
            r_aborted <= w_aborted_set;

            if (w_accept) begin
                r_tgt      <= bus.target;
                r_dwell    <= bus.dwell;
                r_cyc      <= bus.cycles;
                r_cyc_done <= '0;
            end else if (w_cyc_step) begin
                r_cyc_done <= w_cyc_done_inc;
            end

            // Loaded with the dwell on hold entry; the hold exits on the
            // cycle it reads zero, giving dwell+1 hold cycles.
            if (w_hold_load) begin
                r_dwell_cnt <= r_dwell;
            end else if (w_hold_dec) begin
                r_dwell_cnt <= r_dwell_cnt - 1'b1;
            end
        end
    end

    assign bus.enable   = w_enable;
    assign bus.updn     = w_updn;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;
    assign bus.aborted  = r_aborted;
    assign bus.state    = r_state;
    assign bus.cyc_done = r_cyc_done;

endmodule
`default_nettype wire
